// File: rtl/uart_tx_fifo_serializer_if.sv
// TX FIFO / baud / UART line bundle for the serializer.
// master = environment (FIFO, baud generator, config), slave = serializer.
interface uart_tx_fifo_serializer_if;
    logic       baud_en;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_n;
    logic       tx;
    logic       tx_busy;

    modport master (
        output baud_en, bit8, parity_en, odd_n_even, fifo_empty, fifo_data,
        input  fifo_read_n, tx, tx_busy
    );

    modport slave (
        input  baud_en, bit8, parity_en, odd_n_even, fifo_empty, fifo_data,
        output fifo_read_n, tx, tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out as
// start / 7-8 data (LSB first) / optional parity / stop frames. A byte is
// prefetched during the stop bit so consecutive frames run with no idle gap.
module uart_tx_fifo_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    uart_tx_fifo_serializer_if.slave        bus
);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    // One tick before the end of the stop bit: reloading here lets the next
    // start bit begin exactly on the stop bit's final boundary.
    localparam logic [3:0] TICK_PRE  = 4'(OVERSAMPLE - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t     state_q;
    logic [3:0] tick_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic       bit8_q;
    logic       par_en_q;
    logic       start_on_q;
    logic       tx_q;
    logic       read_n_q;
    logic       pend1_q;
    logic       pend2_q;
    logic [7:0] hold_q;
    logic       hold_vld_q;

    logic       pop_inflight;
    logic       stop_last;
    logic       stop_early;
    logic       load_now;
    logic       issue_pop;
    logic [7:0] load_data;
    logic [2:0] last_bit;

    function automatic logic frame_parity(input logic [7:0] d, input logic b8,
                                          input logic odd);
        return (^(d & {b8, 7'h7f})) ^ odd;
    endfunction

    // Read strobe still low or FIFO data still travelling through its pipeline.
    assign pop_inflight = ~read_n_q | pend1_q | pend2_q;
    assign stop_last    = (state_q == S_STOP) && bus.baud_en && (tick_q == TICK_LAST);
    assign stop_early   = (state_q == S_STOP) && bus.baud_en && (tick_q == TICK_PRE);
    // A byte is ready either in the holding register or on fifo_data this cycle.
    assign load_now     = ((state_q == S_WAIT) && pend2_q) ||
                          ((stop_early || stop_last) && (hold_vld_q || pend2_q));
    assign load_data    = hold_vld_q ? hold_q : bus.fifo_data;
    // Never pop an empty FIFO, never stack a second pop on an outstanding one,
    // and never prefetch on the edge that leaves STOP.
    assign issue_pop    = ~bus.fifo_empty && ~pop_inflight && ~hold_vld_q &&
                          ((state_q == S_IDLE) || ((state_q == S_STOP) && ~stop_last));
    assign last_bit     = bit8_q ? 3'd7 : 3'd6;

    assign bus.tx          = tx_q;
    assign bus.fifo_read_n = read_n_q;
    assign bus.tx_busy     = (state_q != S_IDLE) | pop_inflight | hold_vld_q;

    // Frame FSM, pop pipeline, prefetch holding register and line driver.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit8_q     <= 1'b1;
            par_en_q   <= 1'b0;
            start_on_q <= 1'b0;
            tx_q       <= 1'b1;
            read_n_q   <= 1'b1;
            pend1_q    <= 1'b0;
            pend2_q    <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            read_n_q <= ~issue_pop;
            pend1_q  <= ~read_n_q;
            pend2_q  <= pend1_q;

            if (pend2_q && !load_now) begin
                hold_q     <= bus.fifo_data;
                hold_vld_q <= 1'b1;
            end else if (load_now) begin
                hold_vld_q <= 1'b0;
            end

            if (load_now) begin
                // Frame format is frozen here; later config changes wait for the next byte.
                shift_q    <= load_data;
                bit8_q     <= bus.bit8;
                par_en_q   <= bus.parity_en;
                par_q      <= frame_parity(load_data, bus.bit8, bus.odd_n_even);
                tick_q     <= '0;
                bit_q      <= '0;
                start_on_q <= 1'b0;
                state_q    <= S_START;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q <= 1'b1;
                        if (issue_pop) state_q <= S_POP;
                    end
                    S_POP: state_q <= S_WAIT;
                    S_WAIT: ;
                    S_START: begin
                        if (bus.baud_en) begin
                            if (!start_on_q) begin
                                // The load-edge tick is not counted; the bit starts here.
                                tx_q       <= 1'b0;
                                start_on_q <= 1'b1;
                            end else if (tick_q == TICK_LAST) begin
                                tick_q  <= '0;
                                tx_q    <= shift_q[0];
                                shift_q <= shift_q >> 1;
                                state_q <= S_DATA;
                            end else begin
                                tick_q <= tick_q + 4'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (bus.baud_en) begin
                            if (tick_q == TICK_LAST) begin
                                tick_q <= '0;
                                if (bit_q == last_bit) begin
                                    tx_q    <= par_en_q ? par_q : 1'b1;
                                    state_q <= par_en_q ? S_PARITY : S_STOP;
                                end else begin
                                    tx_q    <= shift_q[0];
                                    shift_q <= shift_q >> 1;
                                    bit_q   <= bit_q + 3'd1;
                                end
                            end else begin
                                tick_q <= tick_q + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bus.baud_en) begin
                            if (tick_q == TICK_LAST) begin
                                tick_q  <= '0;
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end else begin
                                tick_q <= tick_q + 4'd1;
                            end
                        end
                    end
                    S_STOP: begin
                        if (bus.baud_en) begin
                            if (tick_q == TICK_LAST) begin
                                tick_q  <= '0;
                                state_q <= pop_inflight ? S_WAIT : S_IDLE;
                            end else begin
                                tick_q <= tick_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Bench for uart_tx_fifo_serializer: FIFO model with the 2-edge read latency,
// a scoreboard of expected frames and a line monitor that decodes tx per baud tick.
module tb_uart_tx_fifo_serializer;
    localparam int OS = 16;

    typedef struct {
        logic [7:0] d;
        bit         b8;
        bit         pe;
        bit         odd;
    } frame_t;

    logic clock;
    logic reset_n;
    uart_tx_fifo_serializer_if bus();

    uart_tx_fifo_serializer #(.OVERSAMPLE(OS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    frame_t     exp_q[$];
    logic [7:0] fifo_q[$];
    logic       empty_r = 1'b1;
    logic [7:0] data_r  = 8'h00;
    logic [7:0] rd_stage = 8'h00;
    int         baud_mode = 0;

    int n_checks = 0;
    int n_fail   = 0;

    int         mon_phase = 0;
    int         bit_idx = 0;
    int         smp_cnt = 0;
    int         bad_cnt = 0;
    int         nbits = 0;
    bit [11:0]  fbits = '0;
    logic [7:0] cur_byte = 8'h00;
    int         idle_ticks = 0;
    int         last_gap = 0;
    int         rd_pulses = 0;
    int         rd_in_stop = 0;

    assign bus.fifo_empty = empty_r;
    assign bus.fifo_data  = data_r;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference frame built straight from the line format rules.
    function automatic void build_frame(input frame_t f, output bit [11:0] fb, output int n);
        bit p;
        int nd;
        fb = '0;
        fb[0] = 1'b0;
        n  = 1;
        nd = f.b8 ? 8 : 7;
        p  = f.odd;
        for (int i = 0; i < nd; i++) begin
            fb[n] = f.d[i];
            p     = p ^ f.d[i];
            n++;
        end
        if (f.pe) begin
            fb[n] = p;
            n++;
        end
        fb[n] = 1'b1;
        n++;
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        bus.baud_en = 1'b1;
        forever begin
            @(negedge clock);
            bus.baud_en = (baud_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    // TX FIFO model: pop on the edge that sees read_n low, data visible one edge later.
    initial begin
        forever begin
            @(posedge clock);
            data_r <= rd_stage;
            if (bus.fifo_read_n == 1'b0 && fifo_q.size() != 0)
                rd_stage <= fifo_q.pop_front();
            empty_r <= (fifo_q.size() == 0);
        end
    end

    // Line monitor / scoreboard consumer.
    initial begin
        bit be;
        bit s;
        frame_t f;
        forever begin
            @(posedge clock);
            be = bus.baud_en;
            @(negedge clock);
            if (!reset_n) begin
                mon_phase  = 0;
                idle_ticks = 0;
                continue;
            end
            if (bus.fifo_read_n == 1'b0) begin
                rd_pulses++;
                if (mon_phase == 1 && bit_idx == nbits - 1) rd_in_stop++;
                check(fifo_q.size() != 0, "read strobe on empty FIFO", fifo_q.size(), 1);
            end
            if (!be) continue;
            s = bus.tx;
            if (mon_phase == 0) begin
                if (s == 1'b0) begin
                    check(exp_q.size() != 0, "start bit with no byte queued", exp_q.size(), 1);
                    if (exp_q.size() != 0) begin
                        f = exp_q.pop_front();
                        build_frame(f, fbits, nbits);
                        cur_byte   = f.d;
                        last_gap   = idle_ticks;
                        idle_ticks = 0;
                        bit_idx    = 0;
                        smp_cnt    = 0;
                        bad_cnt    = 0;
                        mon_phase  = 1;
                    end
                end else begin
                    idle_ticks++;
                end
            end
            if (mon_phase == 1) begin
                if (s != fbits[bit_idx]) bad_cnt++;
                smp_cnt++;
                if (smp_cnt == OS) begin
                    check(bad_cnt == 0,
                          $sformatf("frame %02h bit %0d (level %0b) wrong-tick count",
                                    cur_byte, bit_idx, fbits[bit_idx]), bad_cnt, 0);
                    bit_idx++;
                    smp_cnt = 0;
                    bad_cnt = 0;
                    if (bit_idx == nbits) mon_phase = 0;
                end
            end
        end
    end

    task automatic set_cfg(input bit b8, input bit pe, input bit odd);
        bus.bit8       = b8;
        bus.parity_en  = pe;
        bus.odd_n_even = odd;
    endtask

    task automatic push_byte(input logic [7:0] d);
        frame_t f;
        f.d   = d;
        f.b8  = bus.bit8;
        f.pe  = bus.parity_en;
        f.odd = bus.odd_n_even;
        fifo_q.push_back(d);
        exp_q.push_back(f);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || mon_phase != 0 || fifo_q.size() != 0 ||
                bus.tx_busy !== 1'b0) && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(c < budget, "drain to idle (cycles)", c, budget);
    endtask

    initial begin
        int p0;
        int s0;
        int viol;
        int c;
        int k;
        reset_n = 1'b0;
        set_cfg(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check(bus.tx === 1'b1, "reset tx", int'(bus.tx), 1);
        check(bus.fifo_read_n === 1'b1, "reset fifo_read_n", int'(bus.fifo_read_n), 1);
        check(bus.tx_busy === 1'b0, "reset tx_busy", int'(bus.tx_busy), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 8N1, 0x55
        p0 = rd_pulses;
        push_byte(8'h55);
        wait_done(2000);
        check(rd_pulses - p0 == 1, "0x55 read pulses", rd_pulses - p0, 1);

        // 0xA3 with even then odd parity
        set_cfg(1'b1, 1'b1, 1'b0);
        push_byte(8'hA3);
        wait_done(2000);
        set_cfg(1'b1, 1'b1, 1'b1);
        push_byte(8'hA3);
        wait_done(2000);

        // 7 data bits, even parity, 0xFF
        set_cfg(1'b0, 1'b1, 1'b0);
        push_byte(8'hFF);
        wait_done(2000);

        // Back-to-back 0x11, 0x22
        set_cfg(1'b1, 1'b0, 1'b0);
        p0 = rd_pulses;
        s0 = rd_in_stop;
        push_byte(8'h11);
        push_byte(8'h22);
        wait_done(4000);
        check(rd_pulses - p0 == 2, "back-to-back read pulses", rd_pulses - p0, 2);
        check(rd_in_stop - s0 == 1, "prefetch during stop bit", rd_in_stop - s0, 1);
        check(last_gap == 0, "idle ticks between frames", last_gap, 0);

        // FIFO empty during and after STOP
        p0 = rd_pulses;
        push_byte(8'h3C);
        wait_done(2000);
        viol = 0;
        repeat (1000) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.fifo_read_n !== 1'b1 || bus.tx_busy !== 1'b0) viol++;
        end
        check(viol == 0, "idle with empty FIFO bad cycles", viol, 0);
        check(rd_pulses - p0 == 1, "empty FIFO read pulses", rd_pulses - p0, 1);

        // Reset in the middle of DATA
        push_byte(8'h00);
        c = 0;
        while (!(mon_phase == 1 && bit_idx == 3) && c < 1000) begin
            @(negedge clock);
            c++;
        end
        check(c < 1000, "reach DATA of 0x00 (cycles)", c, 1000);
        #2;
        reset_n = 1'b0;
        #1;
        check(bus.tx === 1'b1, "async reset tx", int'(bus.tx), 1);
        check(bus.tx_busy === 1'b0, "async reset tx_busy", int'(bus.tx_busy), 0);
        check(bus.fifo_read_n === 1'b1, "async reset fifo_read_n", int'(bus.fifo_read_n), 1);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        push_byte(8'h0F);
        wait_done(2000);

        // Randomised batches: random format, baud pacing, bytes and push spacing
        for (int b = 0; b < 8; b++) begin
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            baud_mode = $urandom_range(0, 1);
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                push_byte(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 300)) @(negedge clock);
            end
            wait_done(k * 12 * OS * 6 + 500);
        end
        baud_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
